alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Issue-and-broadcast engine on the producing side of the ALU reservation station's completion interface. Each cycle it selects one ready, not-in-flight reservation-station entry, executes it in a two-stage ALU/compare pipeline, and drives the per-slot `broadcast_bus` that tells the station to free the entry. It drives the tagged result toward the ROB over the same broadcast. It sits between the reservation station outputs (`data`, `acu_operation`, `ready`) and the ROB/CDB.

## Interface
- `size`, 15, number of reservation-station slots; slot index width is `$clog2(size)`.
- `rob_size`, 15, ROB depth; tags are 4 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `flush` input `flush_t`: fields `valid`, `front_tag`, `rear_tag`, `flush_tag`.
- `data` input `rs_t[size]`: reservation-station entries.
  - Uses `tag`, `alu_opcode`, `cmp_opcode`, `funct7`, `r1`, `r2`, `valid`.
- `acu_operation` input 1 x `size`: 1 = compare op, 0 = ALU op.
- `ready` input `size`: entry has both operands resolved.
- `cdb_ready` input 1: CDB/ROB accepts a result this cycle.
- `broadcast_bus` output `sal_t[size]`: `rdy` high on the issuing slot for the accept cycle only; `data` carries the result.
- `result_valid` output 1: a result is accepted by the ROB this cycle.
- `result_tag` output 4: ROB tag of the result.
- `result_data` output 32: result value.
- `busy` output 1: either pipeline stage is occupied.

## Operation
- **Select.** Choose the lowest index `i` where `ready[i] && data[i].valid && !inflight[i]`. Issue is allowed when S1 is empty, or S1 advances this cycle.
- **Stage S1.** Registers `slot`, `tag`, operands, opcode, `funct7[5]` and `acu_operation`.
- **ALU result** (computed from S1, registered into S2):
  - add/sub: `funct7[5]` selects sub.
  - sll, srl/sra: `funct7[5]` selects sra. Shift amount is `r2[4:0]`.
  - xor, or, and.
  - All arithmetic is 32-bit and wraps modulo 2^32.
- **Compare result:** `{31'b0, cmp}` for beq, bne, blt, bge (signed) and bltu, bgeu (unsigned).
- **Stage S2.** Holds `slot`, `tag` and `result`.
  - When `s2_valid && cdb_ready`: assert `broadcast_bus[s2.slot].rdy`, `.data = result`, `result_valid`, `result_tag`, `result_data`.
  - All other `broadcast_bus` entries are 0.
- **Backpressure.**
  - S2 holds while `!cdb_ready`.
  - S1 advances only if S2 is empty or accepting; otherwise S1 holds.
  - No issue occurs while S1 holds.
- **`inflight[size]`.**
  - Bit set on issue.
  - Bit cleared on the edge that ends the accept cycle. This is the same edge at which the station clears the entry, so the entry is never re-selected.
- **Flush** (`flush.valid` high):
  - S1 is invalidated and its `inflight` bit cleared.
  - No issue that cycle.
  - S2 completes normally; the ROB discards stale tags.
  - Surviving station entries are re-selected later.

## Timing
- **Reset values:** `s1_valid`, `s2_valid`, `inflight`, `result_valid`, `result_tag`, `result_data`, `busy` and every `broadcast_bus` field are 0.
  - Reset asserted mid-operation drops both stages immediately.
- **Latency.** Entry ready before edge N:
  - captured into S1 at edge N;
  - captured into S2 at edge N+1;
  - `rdy` is visible in cycle N+1..N+2 if `cdb_ready`.
- **Throughput:** one result per cycle with `cdb_ready` held high.
- **Simultaneous events:**
  - S2 accepting, S1 advancing and a new issue all occur in the same cycle.
  - An entry whose `inflight` bit clears this edge is not selectable until the next cycle.
- **No ready entry:** S1 becomes empty; no bubble-filling.

## Structure
- `rv32i_types` already defines `alu_ops`, `cmp_ops`, `rs_t`, `sal_t` and `flush_t`.
- Add a new `issue_stage_t` (slot, tag, operands, ops, valid) to `rv32i_types`.
- Sub-module `alu_cmp_unit`: purely combinational ALU plus comparator, instantiated between S1 and S2.

## Test plan
- **Single add.** Slot 3 holds add, r1=5, r2=7, tag 2, `cdb_ready`=1.
  - Required: `broadcast_bus[3].rdy` high for exactly one cycle, two cycles after issue.
  - Required: `result_data`=12, `result_tag`=2.
- **Priority.** Slots 1 and 4 ready together.
  - Required: slot 1 broadcast first, slot 4 broadcast on the next cycle.
  - Required: neither slot broadcast twice.
- **Backpressure.** Hold `cdb_ready`=0 for 3 cycles, slot 0 holds sub 3-5.
  - Required: no `rdy` during the stall.
  - Required: 0xFFFFFFFE broadcast on release.
  - Required: S1 holds its entry and no further issue occurs.
- **Compare.** bltu with r1=0xFFFFFFFF, r2=1.
  - Required: result 0.
  - Required: blt with the same operands gives 1.
- **Flush.** Assert `flush.valid` with S1 and S2 both full.
  - Required: S2 result broadcasts.
  - Required: S1 slot never broadcasts that pass.
  - Required: the same slot re-issues after the flush if still valid.
- **Reset.** Assert `rst_n` low mid-stream.
  - Required: all outputs 0 asynchronously.
  - Required: after release, the first issue behaves as in the single-add scenario.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types for the reservation station, issue unit and broadcast path.
// Encodings follow funct3: alu_ops for OP/OP-IMM, cmp_ops for BRANCH.
package rv32i_types;

  localparam int XLEN   = 32;
  localparam int TAG_W  = 4;
  // Wide enough for the 15-entry ALU station.
  localparam int SLOT_W = 4;

  typedef enum logic [2:0] {
    alu_add  = 3'b000,
    alu_sll  = 3'b001,
    alu_slt  = 3'b010,
    alu_sltu = 3'b011,
    alu_xor  = 3'b100,
    alu_sr   = 3'b101,
    alu_or   = 3'b110,
    alu_and  = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    cmp_beq  = 3'b000,
    cmp_bne  = 3'b001,
    cmp_blt  = 3'b100,
    cmp_bge  = 3'b101,
    cmp_bltu = 3'b110,
    cmp_bgeu = 3'b111
  } cmp_ops;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    alu_ops           alu_opcode;
    cmp_ops           cmp_opcode;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  r1;
    logic [XLEN-1:0]  r2;
    logic             valid;
  } rs_t;

  typedef struct packed {
    logic            rdy;
    logic [XLEN-1:0] data;
  } sal_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] front_tag;
    logic [TAG_W-1:0] rear_tag;
    logic [TAG_W-1:0] flush_tag;
  } flush_t;

  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] slot;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   r1;
    logic [XLEN-1:0]   r2;
    alu_ops            alu_op;
    cmp_ops            cmp_op;
    logic              funct7_5;
    logic              acu;
  } issue_stage_t;

endpackage

// File: rtl/alu_cmp_unit.sv
// Combinational ALU and branch comparator between issue stages S1 and S2.
// Zero latency, no state, no backpressure of its own.
module alu_cmp_unit
  import rv32i_types::*;
(
  input  alu_ops            alu_op,
  input  cmp_ops            cmp_op,
  input  logic              funct7_5,
  input  logic              is_cmp,
  input  logic [XLEN-1:0]   r1,
  input  logic [XLEN-1:0]   r2,
  output logic [XLEN-1:0]   result
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            cmp_res;

  assign shamt = r2[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      alu_add:  alu_res = funct7_5 ? (r1 - r2) : (r1 + r2);
      alu_sll:  alu_res = r1 << shamt;
      alu_slt:  alu_res = {{(XLEN-1){1'b0}}, $signed(r1) < $signed(r2)};
      alu_sltu: alu_res = {{(XLEN-1){1'b0}}, r1 < r2};
      alu_xor:  alu_res = r1 ^ r2;
      alu_sr:   alu_res = funct7_5 ? XLEN'($signed(r1) >>> shamt) : (r1 >> shamt);
      alu_or:   alu_res = r1 | r2;
      alu_and:  alu_res = r1 & r2;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    cmp_res = 1'b0;
    case (cmp_op)
      cmp_beq:  cmp_res = (r1 == r2);
      cmp_bne:  cmp_res = (r1 != r2);
      cmp_blt:  cmp_res = ($signed(r1) < $signed(r2));
      cmp_bge:  cmp_res = ($signed(r1) >= $signed(r2));
      cmp_bltu: cmp_res = (r1 < r2);
      cmp_bgeu: cmp_res = (r1 >= r2);
      default:  cmp_res = 1'b0;
    endcase
  end

  assign result = is_cmp ? {{(XLEN-1){1'b0}}, cmp_res} : alu_res;

endmodule

// File: rtl/alu_issue_unit.sv
// Picks the lowest ready entry, runs it through S1 -> S2 and broadcasts when cdb_ready.
// Latency 2 edges to broadcast; S2 stalls on !cdb_ready, S1 and issue stall behind it.
module alu_issue_unit
  import rv32i_types::*;
#(
  parameter int size     = 15,
  parameter int rob_size = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  flush_t                      flush,
  input  rs_t                         data [size],
  input  logic [size-1:0]             acu_operation,
  input  logic [size-1:0]             ready,
  input  logic                        cdb_ready,
  output sal_t                        broadcast_bus [size],
  output logic                        result_valid,
  output logic [$clog2(rob_size)-1:0] result_tag,
  output logic [XLEN-1:0]             result_data,
  output logic                        busy
);

  issue_stage_t      s1, s1_new;
  logic              s2_valid;
  logic [SLOT_W-1:0] s2_slot;
  logic [TAG_W-1:0]  s2_tag;
  logic [XLEN-1:0]   s2_result;
  logic [XLEN-1:0]   alu_out;

  logic [size-1:0]   inflight, inflight_nxt;
  logic              sel_found;
  logic [SLOT_W-1:0] sel_idx;
  logic              s2_accept, s2_free, s1_free, issue;
  logic              unused_ok;

  assign s2_accept = s2_valid && cdb_ready;
  assign s2_free   = !s2_valid || cdb_ready;
  assign s1_free   = !s1.valid || s2_free;
  assign issue     = sel_found && s1_free && !flush.valid;

  // Descending scan so the lowest eligible index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = size - 1; i >= 0; i--) begin
      if (ready[i] && data[i].valid && !inflight[i]) begin
        sel_found = 1'b1;
        sel_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    s1_new          = '0;
    s1_new.valid    = sel_found;
    s1_new.slot     = sel_idx;
    s1_new.tag      = data[sel_idx].tag;
    s1_new.r1       = data[sel_idx].r1;
    s1_new.r2       = data[sel_idx].r2;
    s1_new.alu_op   = data[sel_idx].alu_opcode;
    s1_new.cmp_op   = data[sel_idx].cmp_opcode;
    s1_new.funct7_5 = data[sel_idx].funct7[5];
    s1_new.acu      = acu_operation[sel_idx];
  end

  // Clear on accept/flush before set on issue; an issuing slot is never one being cleared.
  always_comb begin
    inflight_nxt = inflight;
    if (s2_accept) inflight_nxt[s2_slot] = 1'b0;
    if (flush.valid && s1.valid) inflight_nxt[s1.slot] = 1'b0;
    if (issue) inflight_nxt[sel_idx] = 1'b1;
  end

  alu_cmp_unit u_alu_cmp (
    .alu_op   (s1.alu_op),
    .cmp_op   (s1.cmp_op),
    .funct7_5 (s1.funct7_5),
    .is_cmp   (s1.acu),
    .r1       (s1.r1),
    .r2       (s1.r2),
    .result   (alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      s1       <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (flush.valid) begin
        s1.valid <= 1'b0;
      end else if (s1_free) begin
        s1 <= s1_new;
      end
    end
  end

  // A flushed S1 entry is dropped rather than moved into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_slot   <= '0;
      s2_tag    <= '0;
      s2_result <= '0;
    end else if (s2_free) begin
      s2_valid  <= s1.valid && !flush.valid;
      s2_slot   <= s1.slot;
      s2_tag    <= s1.tag;
      s2_result <= alu_out;
    end
  end

  always_comb begin
    for (int i = 0; i < size; i++) begin
      broadcast_bus[i] = '0;
      if (s2_accept && (s2_slot == SLOT_W'(i))) begin
        broadcast_bus[i].rdy  = 1'b1;
        broadcast_bus[i].data = s2_result;
      end
    end
  end

  assign result_valid = s2_accept;
  assign result_tag   = s2_accept ? s2_tag : '0;
  assign result_data  = s2_accept ? s2_result : '0;
  assign busy         = s1.valid || s2_valid;

  always_comb begin
    unused_ok = ^{flush.front_tag, flush.rear_tag, flush.flush_tag};
    for (int i = 0; i < size; i++) begin
      unused_ok = unused_ok ^ (^{data[i].funct7[6], data[i].funct7[4:0]});
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small station model that frees a slot on broadcast.
module tb_alu_issue_unit;
  import rv32i_types::*;

  localparam int N = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  flush_t        flush;
  rs_t           ent [N];
  logic [N-1:0]  acu;
  logic [N-1:0]  ready;
  logic          cdb_ready;
  sal_t          bb [N];
  logic          result_valid;
  logic [3:0]    result_tag;
  logic [31:0]   result_data;
  logic          busy;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cycle = 0;
  int            bc_cnt [N];
  int            bc_cyc [N];
  logic [31:0]   bc_dat [N];
  logic [31:0]   bc_rd  [N];
  logic [3:0]    bc_tag [N];
  int            start;

  alu_issue_unit #(.size(N), .rob_size(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .data          (ent),
    .acu_operation (acu),
    .ready         (ready),
    .cdb_ready     (cdb_ready),
    .broadcast_bus (bb),
    .result_valid  (result_valid),
    .result_tag    (result_tag),
    .result_data   (result_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic rs_t mk(input logic [3:0] tag, input alu_ops a, input cmp_ops c,
                             input logic [6:0] f7, input logic [31:0] a1, input logic [31:0] a2);
    rs_t e;
    e.tag        = tag;
    e.alu_opcode = a;
    e.cmp_opcode = c;
    e.funct7     = f7;
    e.r1         = a1;
    e.r2         = a2;
    e.valid      = 1'b1;
    return e;
  endfunction

  task automatic load(input int s, input rs_t e, input logic is_cmp);
    ent[s]   = e;
    ready[s] = 1'b1;
    acu[s]   = is_cmp;
  endtask

  task automatic clear_log();
    for (int i = 0; i < N; i++) begin
      bc_cnt[i] = 0;
      bc_cyc[i] = -1;
      bc_dat[i] = '0;
      bc_rd[i]  = '0;
      bc_tag[i] = '0;
    end
  endtask

  function automatic int total_bc();
    int t = 0;
    for (int i = 0; i < N; i++) t += bc_cnt[i];
    return t;
  endfunction

  function automatic logic [32:0] bus_or();
    logic [32:0] acc = '0;
    for (int i = 0; i < N; i++) acc = acc | {bb[i].rdy, bb[i].data};
    return acc;
  endfunction

  // One clock: log broadcasts at the negedge, then free broadcast slots just after the edge.
  task automatic cyc();
    logic [N-1:0] snap;
    @(negedge clk);
    cycle++;
    snap = '0;
    for (int i = 0; i < N; i++) begin
      if (bb[i].rdy) begin
        snap[i]   = 1'b1;
        bc_cnt[i] = bc_cnt[i] + 1;
        bc_cyc[i] = cycle;
        bc_dat[i] = bb[i].data;
        bc_rd[i]  = result_data;
        bc_tag[i] = result_tag;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (snap[i]) begin
        ent[i].valid = 1'b0;
        ready[i]     = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic expect_slot(input string nm, input int s, input int when,
                             input logic [31:0] d, input logic [3:0] t);
    check_val({nm, "_count"}, bc_cnt[s], 1);
    check_val({nm, "_cycle"}, bc_cyc[s], when);
    check_val({nm, "_bus_data"}, bc_dat[s], d);
    check_val({nm, "_result_data"}, bc_rd[s], d);
    check_val({nm, "_tag"}, {28'b0, bc_tag[s]}, {28'b0, t});
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = '0;
    acu       = '0;
    ready     = '0;
    cdb_ready = 1'b1;
    for (int i = 0; i < N; i++) ent[i] = '0;
    clear_log();

    #12;
    check_val("reset_result_valid", result_valid, 0);
    check_val("reset_result_tag", result_tag, 0);
    check_val("reset_result_data", result_data, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_bus", bus_or()[31:0] | {31'b0, bus_or()[32]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add on slot 3
    clear_log();
    start = cycle;
    load(3, mk(4'd2, alu_add, cmp_beq, 7'h00, 32'd5, 32'd7), 1'b0);
    run(6);
    expect_slot("add", 3, start + 3, 32'd12, 4'd2);
    check_val("add_idle_busy", busy, 0);

    // Priority: slot 1 before slot 4
    clear_log();
    start = cycle;
    load(1, mk(4'd5, alu_add, cmp_beq, 7'h00, 32'd1, 32'd1), 1'b0);
    load(4, mk(4'd6, alu_xor, cmp_beq, 7'h00, 32'h0000F0F0, 32'h00000FF0), 1'b0);
    run(7);
    expect_slot("prio_s1", 1, start + 3, 32'd2, 4'd5);
    expect_slot("prio_s4", 4, start + 4, 32'h0000FF00, 4'd6);

    // Backpressure: sub 3-5 stalls in S2, slot 2 waits in S1, slot 5 must not issue
    clear_log();
    cdb_ready = 1'b0;
    load(0, mk(4'd7, alu_add, cmp_beq, 7'h20, 32'd3, 32'd5), 1'b0);
    load(2, mk(4'd8, alu_or, cmp_beq, 7'h00, 32'h1, 32'h2), 1'b0);
    load(5, mk(4'd9, alu_and, cmp_beq, 7'h00, 32'hFF00FF00, 32'h0FF00FF0), 1'b0);
    run(5);
    check_val("stall_no_rdy", total_bc(), 0);
    check_val("stall_result_valid", result_valid, 0);
    check_val("stall_busy", busy, 1);
    cdb_ready = 1'b1;
    start = cycle;
    run(6);
    expect_slot("bp_sub", 0, start + 1, 32'hFFFFFFFE, 4'd7);
    expect_slot("bp_or", 2, start + 2, 32'h3, 4'd8);
    expect_slot("bp_and", 5, start + 3, 32'h0F000F00, 4'd9);

    // Compare and shift boundaries, one result per cycle
    clear_log();
    start = cycle;
    load(6,  mk(4'd9,  alu_add, cmp_bltu, 7'h00, 32'hFFFFFFFF, 32'h1), 1'b1);
    load(7,  mk(4'd10, alu_add, cmp_blt,  7'h00, 32'hFFFFFFFF, 32'h1), 1'b1);
    load(8,  mk(4'd11, alu_sr,  cmp_beq,  7'h20, 32'h80000000, 32'd4), 1'b0);
    load(9,  mk(4'd12, alu_sr,  cmp_beq,  7'h00, 32'h80000000, 32'd4), 1'b0);
    load(10, mk(4'd13, alu_sll, cmp_beq,  7'h00, 32'h1, 32'h3F), 1'b0);
    load(11, mk(4'd14, alu_add, cmp_beq,  7'h00, 32'hFFFFFFFF, 32'h1), 1'b0);
    run(10);
    expect_slot("bltu", 6, start + 3, 32'h0, 4'd9);
    expect_slot("blt", 7, start + 4, 32'h1, 4'd10);
    expect_slot("sra", 8, start + 5, 32'hF8000000, 4'd11);
    expect_slot("srl", 9, start + 6, 32'h08000000, 4'd12);
    expect_slot("sll31", 10, start + 7, 32'h80000000, 4'd13);
    expect_slot("add_wrap", 11, start + 8, 32'h0, 4'd14);

    // Flush with S1 (slot 1) and S2 (slot 0) both full
    clear_log();
    start = cycle;
    load(0, mk(4'd1, alu_add, cmp_beq, 7'h00, 32'd10, 32'd20), 1'b0);
    load(1, mk(4'd3, alu_add, cmp_beq, 7'h00, 32'd100, 32'd1), 1'b0);
    run(2);
    flush.valid     = 1'b1;
    flush.front_tag = 4'd1;
    flush.rear_tag  = 4'd6;
    flush.flush_tag = 4'd2;
    cyc();
    flush = '0;
    check_val("flush_s1_dropped", bc_cnt[1], 0);
    run(6);
    expect_slot("flush_s2", 0, start + 3, 32'd30, 4'd1);
    expect_slot("flush_reissue", 1, start + 6, 32'd101, 4'd3);

    // Reset mid-stream with both stages full
    clear_log();
    load(2, mk(4'd4, alu_add, cmp_beq, 7'h00, 32'd1, 32'd2), 1'b0);
    load(3, mk(4'd5, alu_add, cmp_beq, 7'h00, 32'd4, 32'd4), 1'b0);
    run(2);
    check_val("pre_reset_result_valid", result_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_result_valid", result_valid, 0);
    check_val("arst_result_tag", result_tag, 0);
    check_val("arst_result_data", result_data, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_bus", bus_or()[31:0] | {31'b0, bus_or()[32]}, 0);
    for (int i = 0; i < N; i++) ent[i].valid = 1'b0;
    ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    start = cycle;
    load(3, mk(4'd2, alu_add, cmp_beq, 7'h00, 32'd5, 32'd7), 1'b0);
    run(6);
    expect_slot("post_reset_add", 3, start + 3, 32'd12, 4'd2);
    check_val("post_reset_no_other", total_bc(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
